// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of one single-port on-chip RAM.
// Supports a bounded lock so that a master can finish a read-modify-write
// without being interleaved.
// Optional build macro: ONCHIP_ARB_STATS_EN adds saturating grant and
// conflict counters (stat_gnt0, stat_gnt1, stat_conflict).
//
// Handshake: a master holds mN_read/mN_write and its qualifiers stable while
// mN_waitrequest is high. The access is accepted on a rising clock edge when
// the request is high and mN_waitrequest is low. Read data arrives exactly one
// cycle later, as a single-cycle pulse on mN_readdatavalid.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
`ifdef ONCHIP_ARB_STATS_EN
  ,
  output logic [15:0]         stat_gnt0,
  output logic [15:0]         stat_gnt1,
  output logic [15:0]         stat_conflict
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C  = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST_C = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state, state_nxt;
  logic              last_gnt, last_nxt;
  logic              lock_active, lock_nxt;
  logic [CNT_W-1:0]  lock_cnt, cnt_nxt;
  logic              rd_pend, rd_tag;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req0, req1, gnt0, gnt1, accept, win;
  logic              owner_id, owner_req, owner_lk, hold_lock;
  logic              win_wr, win_lk;
  logic [ADDR_W-1:0] win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign owner_id  = (state == OWN1);
  assign owner_req = owner_id ? req1 : req0;
  assign owner_lk  = owner_id ? m1_lock : m0_lock;
  assign hold_lock = lock_active && (state != IDLE);

  // Grant: the locked owner first, then the alternating tie-break, then a lone requester.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      gnt0 = 1'b0;
    end else if (hold_lock && owner_req) begin
      gnt0 = ~owner_id;
      gnt1 = owner_id;
    end else if (hold_lock && owner_lk && (lock_cnt < LOCK_MAX_C)) begin
      gnt0 = 1'b0;  // the owner is idle but still holds the lock: the other master waits
    end else if (req0 && req1) begin
      gnt0 = last_gnt;
      gnt1 = ~last_gnt;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  assign accept    = gnt0 | gnt1;
  assign win       = gnt1;
  assign win_wr    = win ? m1_write : m0_write;
  assign win_lk    = win ? m1_lock : m0_lock;
  assign win_addr  = win ? m1_address : m0_address;
  assign win_be    = win ? m1_byteenable : m0_byteenable;
  assign win_wdata = win ? m1_writedata : m0_writedata;

  assign m0_waitrequest   = req0 & ~gnt0;
  assign m1_waitrequest   = req1 & ~gnt1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_tag & ~reset;
  assign m1_readdatavalid = rd_pend & rd_tag & ~reset;

  // RAM port: driven from the winner; address, lanes and data hold when idle.
  always_comb begin
    mem_chipselect = accept;
    mem_write      = accept & win_wr;
    mem_address    = accept ? win_addr : addr_q;
    mem_byteenable = accept ? (win_wr ? win_be : {BE_W{1'b1}}) : be_q;
    mem_writedata  = accept ? win_wdata : wdata_q;
    mem_clken      = ~reset;
  end

  // Next ownership and lock bookkeeping; lock time counts accepts and idle-held cycles alike.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_gnt;
    lock_nxt  = lock_active;
    cnt_nxt   = lock_cnt;
    if (accept) begin
      cnt_nxt   = (hold_lock && (win == owner_id)) ? lock_cnt + 1'b1 : '0;
      lock_nxt  = win_lk && (cnt_nxt < LOCK_LAST_C);
      state_nxt = win ? OWN1 : OWN0;
      last_nxt  = win;
    end else if (hold_lock) begin
      if (owner_lk && (lock_cnt < LOCK_MAX_C)) begin
        cnt_nxt  = lock_cnt + 1'b1;
        lock_nxt = cnt_nxt < LOCK_LAST_C;
      end else begin
        cnt_nxt  = '0;
        lock_nxt = 1'b0;
      end
    end
  end

  // State, read tracking and held RAM-port values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      rd_pend     <= 1'b0;
      rd_tag      <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      state       <= state_nxt;
      last_gnt    <= last_nxt;
      lock_active <= lock_nxt;
      lock_cnt    <= cnt_nxt;
      rd_pend     <= accept & ~win_wr;
      if (accept) begin
        rd_tag  <= win;
        addr_q  <= mem_address;
        be_q    <= mem_byteenable;
        wdata_q <= mem_writedata;
      end
    end
  end

`ifdef ONCHIP_ARB_STATS_EN
  // Saturating usage counters: accepts per master and contested cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && (stat_gnt0 != 16'hFFFF)) stat_gnt0 <= stat_gnt0 + 16'd1;
      if (gnt1 && (stat_gnt1 != 16'hFFFF)) stat_gnt1 <= stat_gnt1 + 16'd1;
      if (req0 && req1 && (stat_conflict != 16'hFFFF)) stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter (built with LOCK_MAX=4, stats macro undefined).
// A behavioural RAM answers the DUT's memory port; a reference model of the
// arbitration rules and of memory contents predicts every observable output.
module tb_onchip_mem_arbiter;
  localparam int LOCK_MAX = 4;

  logic        clk, reset;
  logic [17:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [17:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int total = 0;
  int bad   = 0;

  onchip_mem_arbiter #(.ADDR_W(18), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural RAM (environment) ----------------
  logic [31:0] tb_ram [0:262143];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) tb_ram[mem_address] <= merge(tb_ram[mem_address], mem_writedata, mem_byteenable);
      else mem_readdata <= tb_ram[mem_address];
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  int          owner = -1, last = 1, used = 0;
  bit          locked = 0, pend = 0;
  int          pend_tag = 0;
  logic [31:0] pend_data = 0;
  logic [17:0] hold_addr = 0;
  logic        obs_w0, obs_w1, obs_rv0, obs_rv1;
  logic [31:0] obs_rd0, obs_rd1;

  function automatic logic [31:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit          rq[2], lk[2], wr[2];
    logic [17:0] ad[2];
    logic [3:0]  be[2];
    logic [31:0] wd[2];
    int          win;
    @(negedge clk);
    rq[0] = m0_read | m0_write;  rq[1] = m1_read | m1_write;
    lk[0] = m0_lock;  lk[1] = m1_lock;  wr[0] = m0_write;  wr[1] = m1_write;
    ad[0] = m0_address;  ad[1] = m1_address;
    be[0] = m0_byteenable;  be[1] = m1_byteenable;
    wd[0] = m0_writedata;  wd[1] = m1_writedata;
    if (reset) win = -1;
    else if (locked && rq[owner]) win = owner;
    else if (locked && lk[owner] && used < LOCK_MAX) win = -1;
    else if (rq[0] && rq[1]) win = 1 - last;
    else if (rq[0]) win = 0;
    else if (rq[1]) win = 1;
    else win = -1;

    obs_w0 = m0_waitrequest;  obs_w1 = m1_waitrequest;
    obs_rv0 = m0_readdatavalid;  obs_rv1 = m1_readdatavalid;
    obs_rd0 = m0_readdata;  obs_rd1 = m1_readdata;

    check("wait0", {31'b0, m0_waitrequest}, {31'b0, rq[0] && win != 0});
    check("wait1", {31'b0, m1_waitrequest}, {31'b0, rq[1] && win != 1});
    check("chipselect", {31'b0, mem_chipselect}, {31'b0, win >= 0});
    check("mem_write", {31'b0, mem_write}, {31'b0, win >= 0 && wr[win]});
    check("clken", {31'b0, mem_clken}, {31'b0, !reset});
    check("mem_addr", {14'b0, mem_address}, {14'b0, (win >= 0) ? ad[win] : hold_addr});
    if (win >= 0) begin
      check("mem_be", {28'b0, mem_byteenable}, {28'b0, wr[win] ? be[win] : 4'hF});
      if (wr[win]) check("mem_wdata", mem_writedata, wd[win]);
    end
    check("rvalid0", {31'b0, m0_readdatavalid}, {31'b0, pend && !reset && pend_tag == 0});
    check("rvalid1", {31'b0, m1_readdatavalid}, {31'b0, pend && !reset && pend_tag == 1});
    if (pend && !reset) check("rdata", (pend_tag == 1) ? m1_readdata : m0_readdata, pend_data);

    @(posedge clk);
    if (reset) begin
      owner = -1;  last = 1;  locked = 0;  used = 0;  pend = 0;  hold_addr = '0;
    end else begin
      pend = 0;
      if (win >= 0) begin
        hold_addr = ad[win];
        if (wr[win]) ref_mem[int'(ad[win])] = merge(ref_rd(ad[win]), wd[win], be[win]);
        else begin
          pend = 1;  pend_tag = win;  pend_data = ref_rd(ad[win]);
        end
        used   = (locked && win == owner) ? used + 1 : 1;
        owner  = win;
        last   = win;
        locked = lk[win] && used < LOCK_MAX;
      end else if (locked) begin
        if (lk[owner] && used < LOCK_MAX) begin
          used++;
          locked = used < LOCK_MAX;
        end else locked = 0;
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    m0_read = 0;  m0_write = 0;  m0_lock = 0;
    m1_read = 0;  m1_write = 0;  m1_lock = 0;
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [17:0] a,
                       input logic [3:0] be, input logic [31:0] d, input bit lk);
    if (m == 0) begin
      m0_read = rd;  m0_write = wr;  m0_address = a;  m0_byteenable = be;
      m0_writedata = d;  m0_lock = lk;
    end else begin
      m1_read = rd;  m1_write = wr;  m1_address = a;  m1_byteenable = be;
      m1_writedata = d;  m1_lock = lk;
    end
  endtask

  logic [17:0] addr_set [12];

  initial begin
    addr_set = '{18'h0, 18'h1, 18'h2, 18'h3, 18'h4, 18'h5, 18'h6, 18'h7,
                 18'h10, 18'h20, 18'h21, 18'h3FFFF};
    reset = 1'b1;
    idle_all();
    drive(0, 0, 0, '0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, '0, 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Pre-fill every address the bench will read.
    foreach (addr_set[i]) begin
      drive(0, 0, 1, addr_set[i], 4'hF, $urandom, 0);
      cycle();
    end
    idle_all();
    cycle();

    // m0 write then read back; m1 silent.
    drive(0, 0, 1, 18'h00010, 4'hF, 32'hDEADBEEF, 0);
    cycle();
    drive(0, 1, 0, 18'h00010, 4'hF, 32'h0, 0);
    cycle();
    idle_all();
    cycle();
    check("t1_rvalid", {31'b0, obs_rv0}, 32'd1);
    check("t1_rdata", obs_rd0, 32'hDEADBEEF);
    check("t1_wait1", {31'b0, obs_w1}, 32'd0);

    // Both masters read every cycle from reset: strict alternation starting with m0.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(0, 1, 0, 18'h20, 4'h0, 32'h0, 0);
    drive(1, 1, 0, 18'h21, 4'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("alt_wait0", {31'b0, obs_w0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("alt_wait1", {31'b0, obs_w1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i > 0) check("alt_rv0", {31'b0, obs_rv0}, ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
    end
    idle_all();
    cycle();

    // m1 locks with continuous requests while m0 waits: 4 m1 accepts, then m0.
    drive(1, 1, 0, 18'h3, 4'h0, 32'h0, 1);
    cycle();
    check("lock_first", {31'b0, obs_w1}, 32'd0);
    drive(0, 1, 0, 18'h4, 4'h0, 32'h0, 0);
    for (int k = 1; k < 4; k++) begin
      cycle();
      check("lock_m1_wait", {31'b0, obs_w1}, 32'd0);
      check("lock_m0_wait", {31'b0, obs_w0}, 32'd1);
    end
    cycle();
    check("lock_m0_turn", {31'b0, obs_w0}, 32'd0);
    check("lock_m1_held", {31'b0, obs_w1}, 32'd1);
    idle_all();
    cycle();

    // Partial byte write at the top address.
    drive(0, 0, 1, 18'h3FFFF, 4'hF, 32'hFFFFFFFF, 0);
    cycle();
    drive(0, 0, 1, 18'h3FFFF, 4'b0101, 32'h11223344, 0);
    cycle();
    drive(0, 1, 0, 18'h3FFFF, 4'h0, 32'h0, 0);
    cycle();
    idle_all();
    cycle();
    check("be_rdata", obs_rd0, 32'hFF22FF44);

    // Reset right after an m1 read accept kills the read; next tie goes to m0.
    drive(1, 1, 0, 18'h5, 4'h0, 32'h0, 0);
    cycle();
    idle_all();
    reset = 1'b1;
    cycle();
    check("rst_rvalid1", {31'b0, obs_rv1}, 32'd0);
    reset = 1'b0;
    drive(0, 1, 0, 18'h6, 4'h0, 32'h0, 0);
    drive(1, 1, 0, 18'h7, 4'h0, 32'h0, 0);
    cycle();
    check("rst_tie_w0", {31'b0, obs_w0}, 32'd0);
    check("rst_tie_w1", {31'b0, obs_w1}, 32'd1);
    idle_all();
    cycle();

    // Randomized traffic. Held requests stay stable while waitrequest is high.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!(m0_waitrequest && (m0_read || m0_write)) || reset) begin
        if ($urandom_range(0, 2) == 0) drive(0, 0, 0, m0_address, m0_byteenable, m0_writedata, $urandom_range(0, 3) == 0);
        else drive(0, $urandom_range(0, 1), $urandom_range(0, 1), addr_set[$urandom_range(0, 11)],
                   4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0);
      end
      if (!(m1_waitrequest && (m1_read || m1_write)) || reset) begin
        if ($urandom_range(0, 2) == 0) drive(1, 0, 0, m1_address, m1_byteenable, m1_writedata, $urandom_range(0, 3) == 0);
        else drive(1, $urandom_range(0, 1), $urandom_range(0, 1), addr_set[$urandom_range(0, 11)],
                   4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
